mult_div_unit: RTL

- Sequential signed multiply/divide unit for the multicycle CPU.
- Sits beside the ALU, directly downstream of the ALU operand-B mux.
- Consumes the A register output and the muxed operand-B bus.
- Produces HI/LO results for the mfhi/mflo paths and a start/done handshake to the control unit.

---
 rtl/mult_div_unit_if.sv | 24 ++
 rtl/mult_div_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - operand/result bundle between control unit and mult_div_unit
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] AOut;
  logic [WIDTH-1:0] ALU2Out;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             busy;
  logic             done;
  logic             divZero;

  modport master (
    output AOut, ALU2Out, start, op,
    input  HI, LO, busy, done, divZero
  );

  modport slave (
    input  AOut, ALU2Out, start, op,
    output HI, LO, busy, done, divZero
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential signed radix-2 Booth multiplier and restoring divider
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic            clk,
  input logic            reset_n,
  mult_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH:0]   acc, acc_d;
  logic [WIDTH-1:0] mq, mq_d;
  logic [WIDTH-1:0] mcand, mcand_d;
  logic             qm1, qm1_d;
  logic             neg_q, neg_q_d;
  logic             neg_r, neg_r_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // One guard bit on acc keeps the add/sub exact when the multiplicand is most negative.
  logic [WIDTH:0]   mcand_ext, booth_sum, booth_acc;
  logic [WIDTH-1:0] booth_mq;

  assign mcand_ext = {mcand[WIDTH-1], mcand};

  always_comb begin
    booth_sum = acc;
    case ({mq[0], qm1})
      2'b01:   booth_sum = acc + mcand_ext;
      2'b10:   booth_sum = acc - mcand_ext;
      default: booth_sum = acc;
    endcase
  end

  assign booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign booth_mq  = {booth_sum[0], mq[WIDTH-1:1]};

  // Partial remainder stays below the divisor magnitude, so bit WIDTH of the diff is a clean borrow.
  logic [WIDTH:0]   div_shift, div_diff, div_rem;
  logic [WIDTH-1:0] div_quo;
  logic             div_ge;

  assign div_shift = {acc[WIDTH-1:0], mq[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_rem   = div_ge ? div_diff : div_shift;
  assign div_quo   = {mq[WIDTH-2:0], div_ge};

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             accept;

  assign a_mag  = bus.AOut[WIDTH-1]    ? (~bus.AOut + WIDTH'(1))    : bus.AOut;
  assign b_mag  = bus.ALU2Out[WIDTH-1] ? (~bus.ALU2Out + WIDTH'(1)) : bus.ALU2Out;
  assign accept = bus.start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    acc_d   = acc;
    mq_d    = mq;
    mcand_d = mcand;
    qm1_d   = qm1;
    neg_q_d = neg_q;
    neg_r_d = neg_r;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;

    case (state)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          cnt_d = '0;
          acc_d = '0;
          qm1_d = 1'b0;
          if (!bus.op) begin
            state_d = MULT;
            mq_d    = bus.ALU2Out;
            mcand_d = bus.AOut;
            dz_d    = 1'b0;
          end else if (bus.ALU2Out == '0) begin
            state_d = DONE;
            dz_d    = 1'b1;
          end else begin
            state_d = DIV;
            mq_d    = a_mag;
            mcand_d = b_mag;
            neg_q_d = bus.AOut[WIDTH-1] ^ bus.ALU2Out[WIDTH-1];
            neg_r_d = bus.AOut[WIDTH-1];
            dz_d    = 1'b0;
          end
        end
      end

      MULT: begin
        acc_d = booth_acc;
        mq_d  = booth_mq;
        qm1_d = mq[0];
        cnt_d = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          hi_d    = booth_acc[WIDTH-1:0];
          lo_d    = booth_mq;
          state_d = DONE;
        end
      end

      DIV: begin
        acc_d = div_rem;
        mq_d  = div_quo;
        cnt_d = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          lo_d    = neg_q ? (~div_quo + WIDTH'(1)) : div_quo;
          hi_d    = neg_r ? (~div_rem[WIDTH-1:0] + WIDTH'(1)) : div_rem[WIDTH-1:0];
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == MULT) || (state_d == DIV);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mq     <= '0;
      mcand  <= '0;
      qm1    <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      acc    <= acc_d;
      mq     <= mq_d;
      mcand  <= mcand_d;
      qm1    <= qm1_d;
      neg_q  <= neg_q_d;
      neg_r  <= neg_r_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dz_q   <= dz_d;
    end
  end

  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.divZero = dz_q;
endmodule
